// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
//
// Bundles every signal between the data-memory port arbiter and its
// surroundings: two requesters (m0 = pipeline LSU, m1 = trace/debug DMA),
// the shared single-ported data memory, and two status outputs.
//
// Parameters
//   ADDR_W  address width (must match the arbiter's ADDR_W)
//   DATA_W  data width    (must match the arbiter's DATA_W)
//
// Signal groups (per requester mX, X = 0/1)
//   mX_req_valid / mX_req_ready   request handshake
//   mX_addr, mX_wen, mX_wdata     request payload (wen: 1 = store, 0 = load)
//   mX_mask                       size: 00 byte, 01 half, 10/11 word
//   mX_resp_valid, mX_rdata       one-cycle response, rdata = 0 for stores
// Shared memory port
//   mem_addr, mem_wen, mem_wdata, mem_mask  driven by the arbiter
//   mem_rdata                               returned by the memory
// Status
//   busy   arbiter is not idle
//   grant  index of the current or last owner
//
// Modports
//   slave   the arbiter's view
//   master  the environment's view (requesters + memory)
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    // Requester 0 (pipeline LSU)
    logic              m0_req_valid;
    logic              m0_req_ready;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_wen;
    logic [DATA_W-1:0] m0_wdata;
    logic [1:0]        m0_mask;
    logic              m0_resp_valid;
    logic [DATA_W-1:0] m0_rdata;

    // Requester 1 (trace/debug DMA)
    logic              m1_req_valid;
    logic              m1_req_ready;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_wen;
    logic [DATA_W-1:0] m1_wdata;
    logic [1:0]        m1_mask;
    logic              m1_resp_valid;
    logic [DATA_W-1:0] m1_rdata;

    // Shared data-memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_mask;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;
    logic              grant;

    modport slave (
        input  m0_req_valid, m0_addr, m0_wen, m0_wdata, m0_mask,
        output m0_req_ready, m0_resp_valid, m0_rdata,
        input  m1_req_valid, m1_addr, m1_wen, m1_wdata, m1_mask,
        output m1_req_ready, m1_resp_valid, m1_rdata,
        output mem_addr, mem_wen, mem_wdata, mem_mask,
        input  mem_rdata,
        output busy, grant
    );

    modport master (
        output m0_req_valid, m0_addr, m0_wen, m0_wdata, m0_mask,
        input  m0_req_ready, m0_resp_valid, m0_rdata,
        output m1_req_valid, m1_addr, m1_wen, m1_wdata, m1_mask,
        input  m1_req_ready, m1_resp_valid, m1_rdata,
        input  mem_addr, mem_wen, mem_wdata, mem_mask,
        output mem_rdata,
        input  busy, grant
    );

endinterface : dmem_port_arbiter_if

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Arbiter and sequencer for the single data-memory port of the load/store
// stage. Two requesters share the port: m0 (pipeline LSU) and m1 (trace/debug
// DMA). One request is latched at a time, driven onto the memory port for
// MEM_LAT cycles, and answered with a one-cycle response to its owner.
//
// Transaction timeline (accept on the clock edge ending cycle k):
//   k                  IDLE   : winner's req_ready high, request latched
//   k+1 .. k+MEM_LAT   ACCESS : mem_* driven, mem_wen only in cycle k+1,
//                               mem_rdata sampled at the end of k+MEM_LAT
//   k+MEM_LAT+1        RESP   : owner's resp_valid high for one cycle
//   k+MEM_LAT+2        IDLE   : next request may be accepted
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  memory read latency in cycles, legal range 1..7
//
// Ports
//   clock    single clock, all state on the rising edge
//   reset    asynchronous, active-high; drops any in-flight transaction
//   bus      dmem_port_arbiter_if.slave (requesters, memory port, status)
//
// Configuration macro
//   DMEM_ARB_RR_EN  defined   : round-robin between m0 and m1 under contention
//                   undefined : fixed priority, m0 always wins
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // MEM_LAT tops out at 7, so the remaining-cycles counter needs 3 bits.
    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wen_q,   wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        mask_q,  mask_d;
    logic              owner_q, owner_d;   // 0 = m0, 1 = m1
    logic              first_q, first_d;   // marks the first ACCESS cycle
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef DMEM_ARB_RR_EN
    logic              last_q,  last_d;    // last owner, resets to m1 so m0 wins first
`endif

    logic              win;                // arbitration winner, 0 = m0, 1 = m1
    logic              m0_ready;
    logic              m1_ready;
    logic              accept;
    logic              in_idle;

    assign in_idle = (state_q == ST_IDLE);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // A lone valid requester always wins. Under contention the winner is m0
    // (fixed priority) or whoever did not own the port last (round-robin).
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        if (bus.m0_req_valid && bus.m1_req_valid) begin
            win = ~last_q;
        end else begin
            win = ~bus.m0_req_valid;
        end
`else
        win = ~bus.m0_req_valid;
`endif
    end

    // Ready is purely combinational from the valids and only ever high in IDLE.
    assign m0_ready = in_idle && bus.m0_req_valid && !win;
    assign m1_ready = in_idle && bus.m1_req_valid &&  win;
    assign accept   = m0_ready || m1_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold/default value first so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        owner_d = owner_q;
        rdata_d = rdata_q;
        first_d = accept;
`ifdef DMEM_ARB_RR_EN
        last_d  = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                    owner_d = win;
`ifdef DMEM_ARB_RR_EN
                    last_d  = win;
`endif
                    if (win) begin
                        addr_d  = bus.m1_addr;
                        wen_d   = bus.m1_wen;
                        wdata_d = bus.m1_wdata;
                        mask_d  = bus.m1_mask;
                    end else begin
                        addr_d  = bus.m0_addr;
                        wen_d   = bus.m0_wen;
                        wdata_d = bus.m0_wdata;
                        mask_d  = bus.m0_mask;
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    // Last ACCESS cycle: capture the read word, or zero for a
                    // store so the requester never sees stale load data.
                    rdata_d = wen_q ? '0 : bus.mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RESP: begin
                // Responses cannot be backpressured: one cycle, then done.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: reset is asynchronous so an in-flight transaction (and mem_wen)
    // is killed the moment reset rises, without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            owner_q <= 1'b0;
            first_q <= 1'b0;
            rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments for all sequential state so every
            // register samples the pre-edge value of its neighbours.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            owner_q <= owner_d;
            first_q <= first_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.m0_req_ready  = m0_ready;
    assign bus.m1_req_ready  = m1_ready;

    assign bus.m0_resp_valid = (state_q == ST_RESP) && !owner_q;
    assign bus.m1_resp_valid = (state_q == ST_RESP) &&  owner_q;

    // One response register serves both requesters; resp_valid says whose it is.
    assign bus.m0_rdata      = rdata_q;
    assign bus.m1_rdata      = rdata_q;

    // Payload comes straight from the latched request and therefore holds its
    // last value outside ACCESS. The write strobe is qualified by the state
    // so an asynchronous reset drops it immediately.
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_mask      = mask_q;
    assign bus.mem_wen       = (state_q == ST_ACCESS) && first_q && wen_q;

    assign bus.busy          = !in_idle;
    assign bus.grant         = owner_q;

endmodule : dmem_port_arbiter

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter. Four instances with different read
// latencies are exercised one after another from a single initial block:
//   u_a  MEM_LAT=2  single load, request waiting during ACCESS/RESP
//   u_b  MEM_LAT=3  contention (4 transactions), then an m1 store
//   u_c  MEM_LAT=1  mask passthrough with a byte-lane memory model, then
//                   back-to-back loads
//   u_d  MEM_LAT=4  reset asserted in the second ACCESS cycle of a store
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
// Define DMEM_ARB_RR_EN for both the RTL and this bench to check round-robin.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c_if ();
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u_a (.clock(clock), .reset(reset), .bus(a_if.slave));
    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_b (.clock(clock), .reset(reset), .bus(b_if.slave));
    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_c (.clock(clock), .reset(reset), .bus(c_if.slave));
    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(4)) u_d (.clock(clock), .reset(reset), .bus(d_if.slave));

    // Single-word memory behind u_c: byte/half stores land in the lane picked
    // by the low address bits (data taken from the low bits of wdata); mask
    // 10 and 11 both write the whole word.
    logic [31:0] c_mem = 32'h0;
    assign c_if.mem_rdata = c_mem;
    always @(posedge clock) begin
        if (c_if.mem_wen) begin
            case (c_if.mem_mask)
                2'b00:   c_mem[{c_if.mem_addr[1:0], 3'b000} +: 8]  <= c_if.mem_wdata[7:0];
                2'b01:   c_mem[{c_if.mem_addr[1], 4'b0000} +: 16]  <= c_if.mem_wdata[15:0];
                default: c_mem <= c_if.mem_wdata;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(output logic valid, output logic [31:0] addr, output logic wen,
                         output logic [31:0] wdata, output logic [1:0] mask,
                         input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [1:0] m);
        valid = v;
        addr  = a;
        wen   = w;
        wdata = d;
        mask  = m;
    endtask

    // One complete MEM_LAT=1 transaction on u_c from m0.
    task automatic c_txn(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] m, input logic [31:0] exp_rd);
        drive(c_if.m0_req_valid, c_if.m0_addr, c_if.m0_wen, c_if.m0_wdata, c_if.m0_mask, 1'b1, a, w, d, m);
        #4;
        check({tag, "_ready"}, c_if.m0_req_ready, 1);
        tick();
        drive(c_if.m0_req_valid, c_if.m0_addr, c_if.m0_wen, c_if.m0_wdata, c_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        #4;
        check({tag, "_mem_mask"}, c_if.mem_mask, m);
        check({tag, "_mem_wen"},  c_if.mem_wen, w);
        check({tag, "_mem_addr"}, c_if.mem_addr, a);
        tick();
        #4;
        check({tag, "_resp"},  c_if.m0_resp_valid, 1);
        check({tag, "_rdata"}, c_if.m0_rdata, w ? 32'h0 : exp_rd);
        tick();
    endtask

    initial begin
        int exp_w;

        drive(a_if.m0_req_valid, a_if.m0_addr, a_if.m0_wen, a_if.m0_wdata, a_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(a_if.m1_req_valid, a_if.m1_addr, a_if.m1_wen, a_if.m1_wdata, a_if.m1_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(b_if.m0_req_valid, b_if.m0_addr, b_if.m0_wen, b_if.m0_wdata, b_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(b_if.m1_req_valid, b_if.m1_addr, b_if.m1_wen, b_if.m1_wdata, b_if.m1_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(c_if.m0_req_valid, c_if.m0_addr, c_if.m0_wen, c_if.m0_wdata, c_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(c_if.m1_req_valid, c_if.m1_addr, c_if.m1_wen, c_if.m1_wdata, c_if.m1_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(d_if.m0_req_valid, d_if.m0_addr, d_if.m0_wen, d_if.m0_wdata, d_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(d_if.m1_req_valid, d_if.m1_addr, d_if.m1_wen, d_if.m1_wdata, d_if.m1_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        a_if.mem_rdata = 32'hDEADBEEF;
        b_if.mem_rdata = 32'hA5A5A5A5;
        d_if.mem_rdata = 32'h0BADF00D;

        // ---------------- reset state ----------------
        reset = 1'b1;
        tick();
        check("rst_busy",     a_if.busy, 0);
        check("rst_grant",    a_if.grant, 0);
        check("rst_mem_wen",  a_if.mem_wen, 0);
        check("rst_mem_addr", a_if.mem_addr, 0);
        check("rst_rdata",    a_if.m0_rdata, 0);
        check("rst_resp0",    a_if.m0_resp_valid, 0);
        check("rst_ready0",   a_if.m0_req_ready, 0);
        tick();
        reset = 1'b0;

        // ---------------- u_a: single load, MEM_LAT=2 ----------------
        // cycle 0: accept
        drive(a_if.m0_req_valid, a_if.m0_addr, a_if.m0_wen, a_if.m0_wdata, a_if.m0_mask, 1'b1, 32'h100, 1'b0, 0, 2'b10);
        #4;
        check("a_c0_ready0", a_if.m0_req_ready, 1);
        check("a_c0_ready1", a_if.m1_req_ready, 0);
        check("a_c0_busy",   a_if.busy, 0);
        // cycle 1: ACCESS, m1 arrives and must wait
        tick();
        drive(a_if.m0_req_valid, a_if.m0_addr, a_if.m0_wen, a_if.m0_wdata, a_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(a_if.m1_req_valid, a_if.m1_addr, a_if.m1_wen, a_if.m1_wdata, a_if.m1_mask, 1'b1, 32'h104, 1'b0, 0, 2'b10);
        #4;
        check("a_c1_busy",     a_if.busy, 1);
        check("a_c1_mem_addr", a_if.mem_addr, 32'h100);
        check("a_c1_mem_wen",  a_if.mem_wen, 0);
        check("a_c1_ready1",   a_if.m1_req_ready, 0);
        // cycle 2: second ACCESS
        tick();
        #4;
        check("a_c2_busy",   a_if.busy, 1);
        check("a_c2_resp0",  a_if.m0_resp_valid, 0);
        check("a_c2_ready1", a_if.m1_req_ready, 0);
        // cycle 3: RESP
        tick();
        #4;
        check("a_c3_resp0",  a_if.m0_resp_valid, 1);
        check("a_c3_rdata",  a_if.m0_rdata, 32'hDEADBEEF);
        check("a_c3_resp1",  a_if.m1_resp_valid, 0);
        check("a_c3_grant",  a_if.grant, 0);
        check("a_c3_ready1", a_if.m1_req_ready, 0);
        // cycle 4: IDLE, waiting m1 accepted, rdata held
        tick();
        #4;
        check("a_c4_busy",   a_if.busy, 0);
        check("a_c4_resp0",  a_if.m0_resp_valid, 0);
        check("a_c4_hold",   a_if.m1_rdata, 32'hDEADBEEF);
        check("a_c4_ready1", a_if.m1_req_ready, 1);
        // cycles 5-6: ACCESS for m1 with new memory data
        tick();
        drive(a_if.m1_req_valid, a_if.m1_addr, a_if.m1_wen, a_if.m1_wdata, a_if.m1_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        a_if.mem_rdata = 32'h11112222;
        tick();
        // cycle 7: RESP to m1
        tick();
        #4;
        check("a_c7_resp1", a_if.m1_resp_valid, 1);
        check("a_c7_resp0", a_if.m0_resp_valid, 0);
        check("a_c7_rdata", a_if.m1_rdata, 32'h11112222);
        check("a_c7_grant", a_if.grant, 1);
        tick();

        // ---------------- u_b: contention, MEM_LAT=3 ----------------
        drive(b_if.m0_req_valid, b_if.m0_addr, b_if.m0_wen, b_if.m0_wdata, b_if.m0_mask, 1'b1, 32'h40, 1'b0, 0, 2'b10);
        drive(b_if.m1_req_valid, b_if.m1_addr, b_if.m1_wen, b_if.m1_wdata, b_if.m1_mask, 1'b1, 32'h80, 1'b0, 0, 2'b10);
        for (int t = 0; t < 4; t++) begin
`ifdef DMEM_ARB_RR_EN
            exp_w = t % 2;
`else
            exp_w = 0;
`endif
            #4;
            check($sformatf("b_cont%0d_ready0", t), b_if.m0_req_ready, (exp_w == 0) ? 1 : 0);
            check($sformatf("b_cont%0d_ready1", t), b_if.m1_req_ready, (exp_w == 1) ? 1 : 0);
            repeat (4) tick();
            #4;
            check($sformatf("b_cont%0d_resp0", t), b_if.m0_resp_valid, (exp_w == 0) ? 1 : 0);
            check($sformatf("b_cont%0d_resp1", t), b_if.m1_resp_valid, (exp_w == 1) ? 1 : 0);
            check($sformatf("b_cont%0d_grant", t), b_if.grant, exp_w);
            check($sformatf("b_cont%0d_rdata", t), b_if.m0_rdata, 32'hA5A5A5A5);
            tick();
        end

        // ---------------- u_b: m1 store, MEM_LAT=3 ----------------
        drive(b_if.m0_req_valid, b_if.m0_addr, b_if.m0_wen, b_if.m0_wdata, b_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        drive(b_if.m1_req_valid, b_if.m1_addr, b_if.m1_wen, b_if.m1_wdata, b_if.m1_mask, 1'b1, 32'h200, 1'b1, 32'h12345678, 2'b10);
        #4;
        check("b_st_ready1", b_if.m1_req_ready, 1);
        check("b_st_ready0", b_if.m0_req_ready, 0);
        tick();
        drive(b_if.m1_req_valid, b_if.m1_addr, b_if.m1_wen, b_if.m1_wdata, b_if.m1_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        #4;
        check("b_st_c1_wen",   b_if.mem_wen, 1);
        check("b_st_c1_addr",  b_if.mem_addr, 32'h200);
        check("b_st_c1_wdata", b_if.mem_wdata, 32'h12345678);
        check("b_st_c1_mask",  b_if.mem_mask, 2'b10);
        tick();
        #4;
        check("b_st_c2_wen",  b_if.mem_wen, 0);
        check("b_st_c2_busy", b_if.busy, 1);
        tick();
        #4;
        check("b_st_c3_wen",  b_if.mem_wen, 0);
        check("b_st_c3_resp", b_if.m1_resp_valid, 0);
        tick();
        #4;
        check("b_st_c4_resp1", b_if.m1_resp_valid, 1);
        check("b_st_c4_resp0", b_if.m0_resp_valid, 0);
        check("b_st_c4_rdata", b_if.m1_rdata, 32'h0);
        check("b_st_c4_grant", b_if.grant, 1);
        tick();

        // ---------------- u_c: mask passthrough, MEM_LAT=1 ----------------
        c_txn("c_byte", 1'b1, 32'h1, 32'h000000AB, 2'b00, 32'h0);
        c_txn("c_half", 1'b1, 32'h2, 32'h00001234, 2'b01, 32'h0);
        c_txn("c_ld11", 1'b0, 32'h0, 32'h0,        2'b11, 32'h1234AB00);
        c_txn("c_st11", 1'b1, 32'h0, 32'hCAFEF00D, 2'b11, 32'h0);
        check("c_mem_word", c_mem, 32'hCAFEF00D);

        // ---------------- u_c: back-to-back loads, MEM_LAT=1 ----------------
        drive(c_if.m0_req_valid, c_if.m0_addr, c_if.m0_wen, c_if.m0_wdata, c_if.m0_mask, 1'b1, 32'h0, 1'b0, 0, 2'b10);
        #4;
        check("c_bb0_ready", c_if.m0_req_ready, 1);
        check("c_bb0_busy",  c_if.busy, 0);
        tick();
        #4;
        check("c_bb1_busy",  c_if.busy, 1);
        check("c_bb1_ready", c_if.m0_req_ready, 0);
        check("c_bb1_wen",   c_if.mem_wen, 0);
        tick();
        #4;
        check("c_bb2_resp",  c_if.m0_resp_valid, 1);
        check("c_bb2_rdata", c_if.m0_rdata, 32'hCAFEF00D);
        check("c_bb2_busy",  c_if.busy, 1);
        tick();
        #4;
        check("c_bb3_ready", c_if.m0_req_ready, 1);
        check("c_bb3_busy",  c_if.busy, 0);
        tick();
        drive(c_if.m0_req_valid, c_if.m0_addr, c_if.m0_wen, c_if.m0_wdata, c_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        #4;
        check("c_bb4_busy", c_if.busy, 1);
        tick();
        #4;
        check("c_bb5_resp", c_if.m0_resp_valid, 1);
        check("c_bb5_busy", c_if.busy, 1);
        tick();
        #4;
        check("c_bb6_busy", c_if.busy, 0);
        check("c_bb6_resp", c_if.m0_resp_valid, 0);
        tick();

        // ---------------- u_d: reset mid-transaction, MEM_LAT=4 ----------------
        drive(d_if.m0_req_valid, d_if.m0_addr, d_if.m0_wen, d_if.m0_wdata, d_if.m0_mask, 1'b1, 32'h300, 1'b1, 32'h55, 2'b10);
        #4;
        check("d_c0_ready", d_if.m0_req_ready, 1);
        tick();
        drive(d_if.m0_req_valid, d_if.m0_addr, d_if.m0_wen, d_if.m0_wdata, d_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        #4;
        check("d_c1_wen", d_if.mem_wen, 1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("d_rst_wen",   d_if.mem_wen, 0);
        check("d_rst_busy",  d_if.busy, 0);
        check("d_rst_resp0", d_if.m0_resp_valid, 0);
        check("d_rst_resp1", d_if.m1_resp_valid, 0);
        tick();
        reset = 1'b0;
        drive(d_if.m0_req_valid, d_if.m0_addr, d_if.m0_wen, d_if.m0_wdata, d_if.m0_mask, 1'b1, 32'h304, 1'b0, 0, 2'b10);
        #4;
        check("d_post_ready", d_if.m0_req_ready, 1);
        check("d_post_busy",  d_if.busy, 0);
        tick();
        drive(d_if.m0_req_valid, d_if.m0_addr, d_if.m0_wen, d_if.m0_wdata, d_if.m0_mask, 1'b0, 0, 1'b0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            #4;
            check($sformatf("d_acc%0d_resp", i), d_if.m0_resp_valid, 0);
            check($sformatf("d_acc%0d_wen", i),  d_if.mem_wen, 0);
            check($sformatf("d_acc%0d_busy", i), d_if.busy, 1);
            tick();
        end
        #4;
        check("d_resp_valid", d_if.m0_resp_valid, 1);
        check("d_resp_rdata", d_if.m0_rdata, 32'h0BADF00D);
        check("d_resp_addr",  d_if.mem_addr, 32'h304);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dmem_port_arbiter
